// File: rtl/seg_scan.sv
// ============================================================================
// Module   : seg_scan
// Brief    : Six-digit multiplexed common-anode seven-segment scanner with
//            blank guard slots and frame-boundary double buffering.
//            Optional macro SEG_SCAN_LZ_BLANK_EN enables leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] bcd,
    input  logic        load,
    input  logic [2:0]  dp_pos,
    output logic [7:0]  seg,
    output logic [5:0]  sel,
    output logic        frame_done
);

    localparam int c_PC_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
    localparam int c_PC_W   = $clog2(c_PC_MAX);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_PC_W-1:0]   r_pc;
    logic [c_PC_W-1:0]   w_pc_nxt;
    logic [2:0]          r_idx;
    logic [2:0]          w_idx_nxt;
    logic                w_boundary;

    logic [23:0]         r_pend_bcd;
    logic [2:0]          r_pend_dp;
    logic [23:0]         r_act_bcd;
    logic [2:0]          r_act_dp;

    logic [3:0]          w_digit;
    logic                w_dp_lit;
    logic                w_lz_blank;
    logic [7:0]          w_show_seg;
    logic [7:0]          w_seg_nxt;
    logic [5:0]          w_sel_nxt;

    // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles render as a dash.
    function automatic logic [6:0] f_seg7(input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = 7'h3F;
        endcase
        return code;
    endfunction

    always_comb begin
        w_digit = 4'd0;
        case (r_idx)
            3'd0:    w_digit = r_act_bcd[3:0];
            3'd1:    w_digit = r_act_bcd[7:4];
            3'd2:    w_digit = r_act_bcd[11:8];
            3'd3:    w_digit = r_act_bcd[15:12];
            3'd4:    w_digit = r_act_bcd[19:16];
            3'd5:    w_digit = r_act_bcd[23:20];
            default: w_digit = 4'd0;
        endcase
    end

`ifdef SEG_SCAN_LZ_BLANK_EN
    // w_lead[i]: digit i and every more significant digit are zero.
    logic [7:0] w_lead;
    always_comb begin
        w_lead    = 8'h00;
        w_lead[5] = (r_act_bcd[23:20] == 4'd0);
        for (int i = 4; i >= 0; i--) begin
            w_lead[i] = w_lead[i+1] && (r_act_bcd[i*4 +: 4] == 4'd0);
        end
    end
    // A dp position of 6/7 means no dp, so it never protects a zero.
    assign w_lz_blank = (r_idx != 3'd0) && w_lead[r_idx] &&
                        ((r_act_dp > 3'd5) || (r_idx > r_act_dp));
`else
    assign w_lz_blank = 1'b0;
`endif

    assign w_dp_lit   = (r_idx == r_act_dp);
    assign w_show_seg = w_lz_blank ? 8'hFF : {~w_dp_lit, f_seg7(w_digit)};

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc + 1'b1;
        w_idx_nxt   = r_idx;
        w_boundary  = 1'b0;
        w_seg_nxt   = 8'hFF;
        w_sel_nxt   = 6'h3F;
        case (r_state)
            ST_BLANK: begin
                if (r_pc == c_PC_W'(BLANK_CYC - 1)) begin
                    w_state_nxt = ST_SHOW;
                    w_pc_nxt    = '0;
                end
            end
            ST_SHOW: begin
                w_sel_nxt = ~(6'b000001 << r_idx);
                w_seg_nxt = w_show_seg;
                if (r_pc == c_PC_W'(CLK_DIV - 1)) begin
                    w_state_nxt = ST_BLANK;
                    w_pc_nxt    = '0;
                    w_boundary  = (r_idx == 3'd5);
                    w_idx_nxt   = (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_pc_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BLANK;
            r_pc    <= '0;
            r_idx   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // A load landing on the boundary cycle bypasses pending straight to active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_bcd <= 24'h0;
            r_pend_dp  <= 3'd7;
            r_act_bcd  <= 24'h0;
            r_act_dp   <= 3'd7;
        end else begin
            if (load) begin
                r_pend_bcd <= bcd;
                r_pend_dp  <= dp_pos;
            end
            if (w_boundary) begin
                r_act_bcd <= load ? bcd    : r_pend_bcd;
                r_act_dp  <= load ? dp_pos : r_pend_dp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= 8'hFF;
            sel        <= 6'h3F;
            frame_done <= 1'b0;
        end else begin
            seg        <= w_seg_nxt;
            sel        <= w_sel_nxt;
            frame_done <= w_boundary;
        end
    end

endmodule

`default_nettype wire

// File: doc/seg_scan.md
Name: seg_scan

Overview:
Six-digit multiplexed seven-segment driver. Sits directly downstream of the binary-to-BCD converter: it captures the 24-bit packed BCD word on that stage's done pulse and drives one common-anode display digit at a time. Each digit slot has a blanking guard interval before it to prevent ghosting. New data is double-buffered so that it is only applied at a frame boundary, which keeps frames from tearing.

Parameters:
CLK_DIV, 50000, clocks per digit SHOW phase (>=2)
BLANK_CYC, 500, clocks per digit BLANK guard phase (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
bcd  input  24  packed BCD; bcd[3:0]=digit0 (rightmost, least significant) .. bcd[23:20]=digit5
load  input  1  one-cycle capture strobe; connects to the converter's done
dp_pos  input  3  decimal point position 0-5, captured with load; 6/7 = no dp
seg  output  8  registered segments, active-low; {dp,g,f,e,d,c,b,a}
sel  output  6  registered digit enables, active-low; sel[i] selects digit i
frame_done  output  1  one-cycle pulse at the end of each 6-digit frame

Behaviour:
- Reset is asynchronous and active-low. The clock and reset ports are named clk and rst_n.
- Reset values: seg=8'hFF, sel=6'h3F, frame_done=0, state=BLANK, idx=0, phase counter=0, pending and active registers=0, dp=none.
- Double buffering:
  - load=1 captures bcd and dp_pos into the pending register.
  - At each frame boundary, active <= pending.
  - If load coincides with the boundary cycle, the new bcd/dp_pos go straight to active (and to pending).
  - Multiple loads within one frame: the last one wins.
- FSM with two states per digit slot, using phase counter pc:
  - BLANK: sel=6'h3F, seg=8'hFF. Stays for BLANK_CYC clocks, then goes to SHOW with pc cleared.
  - SHOW: sel has only bit idx low; seg holds the code for active digit idx. Stays for CLK_DIV clocks, then goes to BLANK and idx advances.
- idx counts 0..5 and wraps 5->0.
- Frame boundary: the last SHOW cycle of idx=5. In that cycle the buffer transfer happens and frame_done is registered high for exactly one cycle.
- Slot length = BLANK_CYC+CLK_DIV clocks; frame length = 6*(BLANK_CYC+CLK_DIV) clocks.
- Outputs are registered. seg and sel change together one clock after the internal state or idx change.
- Segment codes (active-low, dp off): 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8, 8:80, 9:90.
- Nibble values 10-15 are illegal and display a dash, 8'hBF (segment g only).
- When idx == captured dp_pos, seg[7] is driven 0 (dp lit).
- Reset asserted mid-frame forces all outputs and counters to their reset values immediately, and any pending data is lost.
- load is honoured in every state. It has no effect on scan timing.

Optional Feature:
Macro: SEG_SCAN_LZ_BLANK_EN.
- Defined: leading-zero suppression.
  - A digit is blanked (seg=8'hFF while its sel is still asserted) when it is 0, every more significant digit is 0, its index is above the active dp position, and it is not digit 0.
  - Digit 0 is never blanked.
  - The decision uses the active register only.
- Undefined: all six digits are always displayed, including leading zeros.

Test Plan:
- Reset check: hold rst_n=0 -> seg=FF, sel=3F, frame_done=0. Release -> first 1 cycle (BLANK_CYC=1, CLK_DIV=4) has sel=3F.
- Normal scan: load bcd=24'h123456 with dp_pos=7, then let the frame boundary pass. In the following frame, expect:
  - sel=3E with seg=82 for 4 clocks,
  - then sel=3D with seg=92,
  - then sel=3B/99, 37/B0, 2F/A4, 1F/F9,
  - each slot preceded by 1 clock of 3F/FF;
  - frame_done pulses once every 30 clocks.
- Tear-free update: load 24'h000000 in the middle of digit 2's SHOW phase -> the current frame keeps showing the old digits; the new value appears from digit 0 of the next frame.
- Illegal digit plus dp: load bcd=24'h00000A, dp_pos=0 -> digit 0 shows seg=3F (dash with dp lit).
- Leading zeros: load 24'h000042, dp_pos=7 -> with SEG_SCAN_LZ_BLANK_EN, digits 2-5 show FF and digits 1/0 show 99/A4. Without the macro, digits 2-5 show C0.
- Mid-frame reset: pulse rst_n low during digit 3's SHOW phase -> outputs go to FF/3F asynchronously and scanning restarts at idx 0 with active=0.
